audio_pdm_decimator: RTL
========================

// Module: audio_pdm_decimator
// PURPOSE
// - Receive-side counterpart of the team's 1-bit delta-sigma PWM/PDM modulator: recovers signed PCM samples from a 1-bit density stream.
// - 2nd-order CIC (sinc^2) decimator by R = 2**DECIM_LOG2, followed by clamp, truncation and offset-to-signed conversion.
// - Sits between a PDM source (mic, comparator, loopback of the PWM output) and the audio sample path; output format matches the modulator's signed input.
// PARAMETERS
// - WIDTH       12  output sample width, two's complement; must satisfy WIDTH <= 2*DECIM_LOG2
// - DECIM_LOG2  6   log2 of decimation ratio R (default R = 64)
// PORTS
// - clk           in   1      system clock
// - reset         in   1      synchronous, active-high
// - in_en         in   1      input bit strobe; pdm_in accepted only on cycles with in_en = 1
// - pdm_in        in   1      1-bit density stream; 1 = full positive, 0 = full negative
// - sample        out  WIDTH  decimated signed sample, held between strobes
// - sample_valid  out  1      one-clk pulse when sample updates
// BEHAVIOUR
// - Internal width N = 2*DECIM_LOG2 + 1; all integrator/comb arithmetic is unsigned, modulo 2**N; wrap-around is intentional and must not be saturated.
// - Integrators, on each in_en cycle: I1 <= I1 + pdm_in; I2 <= I2 + I1_next (I1_next = value being written to I1 on the same edge).
// - Decimation counter cnt (DECIM_LOG2 bits) increments on each in_en and wraps R-1 -> 0; the accepting edge with cnt = R-1 is the decimation tick.
// - Comb stage 1, on the edge after a tick: C1 <= I2 - I2_d; I2_d <= I2.
// - Comb stage 2, on the next edge: C2 = C1 - C1_d; C1_d <= C1.
// - Output formation on that same edge:
//   - Clamp: v = (C2 == 2**(2*DECIM_LOG2)) ? 2**(2*DECIM_LOG2) - 1 : C2.
//   - Truncate: t = v >> (2*DECIM_LOG2 - WIDTH).
//   - Sign: sample <= {~t[WIDTH-1], t[WIDTH-2:0]}.
// - Latency: sample and sample_valid update 2 clk after the tick edge; sample_valid is high for exactly 1 clk.
// - Input timing: in_en may arrive every clk or sparsely; the comb pipeline runs on clk, not on in_en.
// - Minimum in_en spacing: R >= 2 guarantees no tick can occur while the comb pipeline is busy.
// - Priming: the first 2 ticks after reset update state but do not assert sample_valid; the first pulse follows the 3rd tick.
// - Priming state: held in a 2-bit prime counter that saturates at 2.
// - Reset values: I1, I2, I2_d, C1, C1_d, cnt, prime = 0; sample = 0; sample_valid = 0.
// - Reset mid-operation: any pending pipeline result is discarded, no sample_valid issues from it, and priming restarts.
// - Simultaneous in_en and pipeline activity: both proceed on the same edge; no stall and no handshake back-pressure.
// - Clamp: a full-scale all-ones window (C2 = 4096 at default) yields +max (0x7FF), never wraps to negative.
// - Unused/steady in_en = 0: all state holds, sample holds, no sample_valid pulses.
// CONFIGURATION
// - PDM_SYNC_EN defined:
//   - pdm_in passes through a 2-flop synchronizer (reset to 0) before the integrator; it is sampled every clk.
//   - Bits entering the integrator are delayed 2 clk relative to pdm_in; in_en is NOT delayed, so the source must hold pdm_in stable >= 3 clk around each in_en.
// - PDM_SYNC_EN undefined:
//   - pdm_in feeds the integrator directly (source synchronous to clk); zero added latency.
// TESTING
// - reset, then pdm_in = 1 with in_en = 1 every clk for 5*64 clk -> sample_valid pulses every 64 clk from the 3rd tick; sample = 0x7FF (clamped).
// - pdm_in = 0 continuous with in_en every clk -> after priming, sample = 0x800 (-2048) on every pulse.
// - pdm_in alternating 1,0,... with in_en every clk -> sample = 0x000 on every valid pulse after priming.
// - in_en once every 4 clk, pdm_in = 1 -> sample_valid period = 256 clk; sample = 0x7FF; no pulse during first 2 ticks.
// - loopback from audio modulator driven with data = 0x400 (+1024), in_en every clk -> steady samples within 0x400 +/- 32.
// - reset asserted 1 clk after a tick -> no sample_valid for that tick; next pulse only after 3 further ticks; sample = 0 meanwhile.

Source files
------------

// File: rtl/audio_pdm_decimator_if.sv
// PDM input strobe/bit and decimated PCM sample output bundle.
// Combinational wiring only; no latency.
// No backpressure: source strobes bits, sink must take every sample pulse.
interface audio_pdm_decimator_if #(
  parameter int WIDTH = 12
);
  logic             in_en;
  logic             pdm_in;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;

  // PDM source side: drives bits, observes recovered samples
  modport master (
    output in_en,
    output pdm_in,
    input  sample,
    input  sample_valid
  );

  // Decimator side
  modport slave (
    input  in_en,
    input  pdm_in,
    output sample,
    output sample_valid
  );
endinterface

// File: rtl/audio_pdm_decimator.sv
// 2nd-order CIC decimator (R = 2**DECIM_LOG2) turning a 1-bit PDM stream into signed PCM.
// Latency: sample/sample_valid update 2 clk after the decimation tick edge.
// No backpressure: every in_en bit is consumed; optional input synchronizer via PDM_SYNC_EN.
module audio_pdm_decimator #(
  parameter int WIDTH      = 12,
  parameter int DECIM_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  audio_pdm_decimator_if.slave  bus
);
  localparam int N     = 2*DECIM_LOG2 + 1;
  localparam int SHIFT = 2*DECIM_LOG2 - WIDTH;
  localparam logic [N-1:0] FULL = N'(1) << (2*DECIM_LOG2);

  logic                  w_bit;
  logic [N-1:0]          r_i1, r_i2, r_i2_d, r_c1, r_c1_d;
  logic [DECIM_LOG2-1:0] r_cnt;
  logic                  r_tick_d1, r_tick_d2;
  logic [1:0]            r_prime;
  logic [WIDTH-1:0]      r_sample;
  logic                  r_sample_valid;

  logic [N-1:0]          w_i1_next, w_c2, w_v;
  logic [WIDTH-1:0]      w_t, w_sample;
  logic                  w_tick;

`ifdef PDM_SYNC_EN
  logic [1:0] r_sync;
  // Two-flop synchronizer for an asynchronous PDM source, sampled every clk
  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], bus.pdm_in};
  end
  assign w_bit = r_sync[1];
`else
  assign w_bit = bus.pdm_in;
`endif

  assign w_i1_next = r_i1 + N'(w_bit);
  assign w_tick    = bus.in_en && (r_cnt == {DECIM_LOG2{1'b1}});

  // Second comb difference and output formatting: clamp the single overflow
  // code (all-ones window) to +max, drop LSBs, flip MSB for offset->signed.
  assign w_c2     = r_c1 - r_c1_d;
  assign w_v      = (w_c2 == FULL) ? (FULL - N'(1)) : w_c2;
  assign w_t      = WIDTH'(w_v >> SHIFT);
  assign w_sample = {~w_t[WIDTH-1], w_t[WIDTH-2:0]};

  // Integrators and decimation counter advance only on accepted bits; wrap is intended
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_cnt <= '0;
    end else if (bus.in_en) begin
      r_i1  <= w_i1_next;
      r_i2  <= r_i2 + w_i1_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Comb pipeline runs on clk, triggered by the delayed tick; reset drops in-flight work
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_d1      <= 1'b0;
      r_tick_d2      <= 1'b0;
      r_i2_d         <= '0;
      r_c1           <= '0;
      r_c1_d         <= '0;
      r_prime        <= 2'd0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_tick_d1      <= w_tick;
      r_tick_d2      <= r_tick_d1;
      r_sample_valid <= 1'b0;
      if (r_tick_d1) begin
        r_c1   <= r_i2 - r_i2_d;
        r_i2_d <= r_i2;
      end
      if (r_tick_d2) begin
        r_c1_d <= r_c1;
        // The first two results still contain start-up history; hold them back
        if (r_prime == 2'd2) begin
          r_sample       <= w_sample;
          r_sample_valid <= 1'b1;
        end else begin
          r_prime <= r_prime + 2'd1;
        end
      end
    end
  end

  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_sample_valid;
endmodule
